// File: rtl/ups2x.sv
// 2x nearest-neighbour upsampler: each half-res beat is widened horizontally and
// each row is replayed from the lsu buffer. Define UPS_BILINEAR_H_EN for in-beat linear interpolation.

module lsu #(
   parameter int IMAGE_DIM  = 512,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] read_ptr,
   output logic [DATA_WIDTH-1:0] read_data,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_ptr,
   input  logic [DATA_WIDTH-1:0] write_data
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   if ((IMAGE_DIM / 2) > DEPTH * (DATA_WIDTH / 8)) begin : g_size_check
      $error("lsu: ADDR_WIDTH too small for one half-res row");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // single-port-per-direction RAM, one-cycle registered read
   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem[write_ptr] <= write_data;
      end
      if (read_enable) begin
         read_data <= mem[read_ptr];
      end
   end
endmodule

module ups2x #(
   parameter int IMAGE_DIM  = 512,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  stall,
   input  logic                  ivalid,
   output logic                  iready,
   input  logic [DATA_WIDTH-1:0] idata,
   output logic                  ovalid,
   output logic [DATA_WIDTH-1:0] odata,
   output logic                  olast,
   output logic                  oframe_done
);
   localparam int PIX    = DATA_WIDTH / 8;
   localparam int IBEATS = (IMAGE_DIM / 2) / PIX;
   localparam int ROWS   = IMAGE_DIM / 2;
   localparam int PW     = $clog2(IBEATS + 1);
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [PW-1:0] IBEATS_P = PW'(IBEATS);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   typedef enum logic [1:0] {ROW_IN = 2'd0, PRIME = 2'd1, REPLAY = 2'd2} state_t;

   state_t                state_r;
   logic                  phase_r;
   logic [PW-1:0]         wptr_r;
   logic [PW-1:0]         rptr_r;
   logic [RW-1:0]         row_r;
   logic                  last_r;
   logic                  rd_pend_r;
   logic [DATA_WIDTH-1:0] hold_r;
   logic [DATA_WIDTH-1:0] prefetch_r;
   logic [DATA_WIDTH-1:0] read_data_s;
   logic [DATA_WIDTH-1:0] pf_s;
   logic                  rd_en_s;
   logic [ADDR_WIDTH-1:0] rd_ptr_s;
   logic                  wr_en_s;

   // upper=0 yields output pixels 0..PIX-1 of the widened beat, upper=1 yields PIX..2*PIX-1
   function automatic logic [DATA_WIDTH-1:0] expand(input logic [DATA_WIDTH-1:0] p, input logic upper);
      logic [DATA_WIDTH-1:0] r;
      logic [8:0]            sum;
      int                    j;
      int                    src;
      r   = '0;
      sum = 9'd0;
      for (int k = 0; k < PIX; k++) begin
         j   = (upper ? PIX : 0) + k;
         src = j / 2;
`ifdef UPS_BILINEAR_H_EN
         if ((j % 2) == 0 || src == PIX - 1) begin
            r[8*k +: 8] = p[8*src +: 8];
         end else begin
            sum = {1'b0, p[8*src +: 8]} + {1'b0, p[8*(src+1) +: 8]} + 9'd1;
            r[8*k +: 8] = sum[8:1];
         end
`else
         r[8*k +: 8] = p[8*src +: 8];
`endif
      end
      return r;
   endfunction

   // handshake, BRAM port control and prefetch bypass
   always_comb begin
      iready   = (state_r == ROW_IN) && !phase_r && !stall;
      wr_en_s  = iready && ivalid && aresetn;
      rd_en_s  = 1'b0;
      rd_ptr_s = '0;
      if (!stall && aresetn) begin
         if (state_r == PRIME) begin
            rd_en_s = 1'b1;
         end else if (state_r == REPLAY && !phase_r && rptr_r < IBEATS_P) begin
            rd_en_s  = 1'b1;
            rd_ptr_s = ADDR_WIDTH'(rptr_r);
         end else begin
            rd_en_s = 1'b0;
         end
      end else begin
         rd_en_s = 1'b0;
      end
      // a read issued last cycle is consumed straight from the RAM output
      pf_s = rd_pend_r ? read_data_s : prefetch_r;
   end

   lsu #(IMAGE_DIM, DATA_WIDTH, ADDR_WIDTH) u_lsu (
      .clk          (clk),
      .read_enable  (rd_en_s),
      .read_ptr     (rd_ptr_s),
      .read_data    (read_data_s),
      .write_enable (wr_en_s),
      .write_ptr    (ADDR_WIDTH'(wptr_r)),
      .write_data   (idata)
   );

   // row fill / prime / replay sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_r     <= ROW_IN;
         phase_r     <= 1'b0;
         wptr_r      <= '0;
         rptr_r      <= '0;
         row_r       <= '0;
         last_r      <= 1'b0;
         rd_pend_r   <= 1'b0;
         hold_r      <= '0;
         prefetch_r  <= '0;
         ovalid      <= 1'b0;
         odata       <= '0;
         olast       <= 1'b0;
         oframe_done <= 1'b0;
      end else begin
         rd_pend_r <= rd_en_s;
         if (rd_pend_r) begin
            prefetch_r <= read_data_s;
         end else begin
            prefetch_r <= prefetch_r;
         end
         if (!stall) begin
            case (state_r)
               ROW_IN: begin
                  if (!phase_r) begin
                     olast       <= 1'b0;
                     oframe_done <= 1'b0;
                     if (ivalid) begin
                        hold_r  <= idata;
                        wptr_r  <= wptr_r + PW'(1);
                        odata   <= expand(idata, 1'b0);
                        ovalid  <= 1'b1;
                        phase_r <= 1'b1;
                     end else begin
                        ovalid <= 1'b0;
                     end
                  end else begin
                     odata   <= expand(hold_r, 1'b1);
                     ovalid  <= 1'b1;
                     phase_r <= 1'b0;
                     olast   <= (wptr_r == IBEATS_P);
                     if (wptr_r == IBEATS_P) begin
                        wptr_r  <= '0;
                        state_r <= PRIME;
                     end else begin
                        state_r <= ROW_IN;
                     end
                  end
               end
               PRIME: begin
                  ovalid      <= 1'b0;
                  olast       <= 1'b0;
                  oframe_done <= 1'b0;
                  rptr_r      <= PW'(1);
                  phase_r     <= 1'b0;
                  state_r     <= REPLAY;
               end
               REPLAY: begin
                  if (!phase_r) begin
                     hold_r      <= pf_s;
                     odata       <= expand(pf_s, 1'b0);
                     ovalid      <= 1'b1;
                     olast       <= 1'b0;
                     oframe_done <= 1'b0;
                     last_r      <= (rptr_r == IBEATS_P);
                     if (rptr_r < IBEATS_P) begin
                        rptr_r <= rptr_r + PW'(1);
                     end else begin
                        rptr_r <= rptr_r;
                     end
                     phase_r <= 1'b1;
                  end else begin
                     odata   <= expand(hold_r, 1'b1);
                     ovalid  <= 1'b1;
                     phase_r <= 1'b0;
                     olast   <= last_r;
                     if (last_r) begin
                        rptr_r  <= '0;
                        state_r <= ROW_IN;
                        if (row_r == LAST_ROW) begin
                           oframe_done <= 1'b1;
                           row_r       <= '0;
                        end else begin
                           row_r <= row_r + RW'(1);
                        end
                     end else begin
                        state_r <= REPLAY;
                     end
                  end
               end
               default: begin
                  state_r <= ROW_IN;
                  phase_r <= 1'b0;
                  ovalid  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ups2x.sv
// Randomised scoreboard bench for ups2x at IMAGE_DIM=64 (IBEATS=2, 32 rows per frame).
module tb_ups2x;
   localparam int IMAGE_DIM = 64;
   localparam int DW        = 128;
   localparam int PIX       = DW / 8;
   localparam int IBEATS    = (IMAGE_DIM / 2) / PIX;
   localparam int ROWS      = IMAGE_DIM / 2;
   localparam int TOTAL     = 2 * ROWS * IBEATS;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          stall;
   logic          ivalid;
   logic          iready;
   logic [DW-1:0] idata;
   logic          ovalid;
   logic [DW-1:0] odata;
   logic          olast;
   logic          oframe_done;

   ups2x #(.IMAGE_DIM(IMAGE_DIM), .DATA_WIDTH(DW), .ADDR_WIDTH(14)) dut (
      .clk(clk), .aresetn(aresetn), .stall(stall), .ivalid(ivalid), .iready(iready),
      .idata(idata), .ovalid(ovalid), .odata(odata), .olast(olast), .oframe_done(oframe_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
      bit            fd;
      bit            gap;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] row_buf[$];
   int            row_idx = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   int            frame_pulses = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Reference: build the whole 2*PIX-pixel widened line, then cut it into two beats
   function automatic logic [DW-1:0] ref_half(input logic [DW-1:0] p, input bit upper);
      int            line [2*PIX];
      int            a;
      int            b;
      logic [DW-1:0] r;
      for (int i = 0; i < PIX; i++) begin
         a = int'(p[8*i +: 8]);
         line[2*i] = a;
`ifdef UPS_BILINEAR_H_EN
         if (i == PIX - 1) line[2*i+1] = a;
         else begin
            b = int'(p[8*(i+1) +: 8]);
            line[2*i+1] = (a + b + 1) / 2;
         end
`else
         b = a;
         line[2*i+1] = b;
`endif
      end
      r = '0;
      for (int k = 0; k < PIX; k++) r[8*k +: 8] = 8'(line[(upper ? PIX : 0) + k]);
      return r;
   endfunction

   task automatic model_accept(input logic [DW-1:0] d);
      exp_t e;
      row_buf.push_back(d);
      e = '{d: ref_half(d, 1'b0), last: 1'b0, fd: 1'b0, gap: 1'b0};
      q.push_back(e);
      e = '{d: ref_half(d, 1'b1), last: (row_buf.size() == IBEATS), fd: 1'b0, gap: 1'b0};
      q.push_back(e);
      if (row_buf.size() == IBEATS) begin
         for (int k = 0; k < IBEATS; k++) begin
            e = '{d: ref_half(row_buf[k], 1'b0), last: 1'b0, fd: 1'b0, gap: (k == 0)};
            q.push_back(e);
            e = '{d: ref_half(row_buf[k], 1'b1), last: (k == IBEATS - 1),
                  fd: (k == IBEATS - 1) && (row_idx == ROWS - 1), gap: 1'b0};
            q.push_back(e);
         end
         row_idx = (row_idx + 1) % ROWS;
         row_buf.delete();
      end
   endtask

   // Monitor: an output beat is consumed on the one unstalled cycle it is presented
   initial begin
      bit   acc_prev = 1'b0;
      bit   prev_ov  = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            acc_prev = 1'b0;
            prev_ov  = 1'b0;
         end else begin
            if (acc_prev) chk("accept_latency_ovalid", DW'(ovalid), DW'(1));
            if (!stall) begin
               if (ovalid) begin
                  if (q.size() == 0) begin
                     chk("unexpected_beat", DW'(1), DW'(0));
                  end else begin
                     e = q.pop_front();
                     chk("odata", odata, e.d);
                     chk("olast", DW'(olast), DW'(e.last));
                     chk("oframe_done", DW'(oframe_done), DW'(e.fd));
                     if (e.gap) chk("prime_bubble", DW'(prev_ov), DW'(0));
                     if (oframe_done) frame_pulses++;
                  end
               end else begin
                  chk("idle_flags", DW'({olast, oframe_done}), DW'(0));
               end
               prev_ov = ovalid;
            end
            if (iready) chk("iready_while_busy", DW'(q.size()), DW'(0));
            acc_prev = ivalid && iready;
            if (acc_prev) model_accept(idata);
         end
      end
   end

   function automatic logic [DW-1:0] gen_beat(input int n);
      logic [DW-1:0] r;
      r = '0;
      if (n == 0) begin
         for (int k = 0; k < PIX; k++) r[8*k +: 8] = 8'(16 * (k + 1));
      end else if (n < TOTAL / 2) begin
         for (int k = 0; k < PIX; k++) r[8*k +: 8] = 8'(n * PIX + k);
      end else begin
         r = {$urandom, $urandom, $urandom, $urandom};
      end
      return r;
   endfunction

   initial begin
      bit acc;
      int fed;
      int cyc;
      int stall_cnt;
      logic [DW-1:0] beat0;
      aresetn = 1'b0; stall = 1'b0; ivalid = 1'b0; idata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ovalid", DW'(ovalid), DW'(0));
      chk("reset_odata", odata, DW'(0));
      chk("reset_flags", DW'({olast, oframe_done}), DW'(0));
      aresetn = 1'b1;

      // one beat of a row, then reset mid-row
      for (int k = 0; k < PIX; k++) beat0[8*k +: 8] = 8'(k);
      ivalid = 1'b1; idata = beat0;
      cyc = 0;
      do begin
         @(negedge clk); acc = ivalid && iready;
         @(posedge clk); #1; cyc++;
      end while (!acc && cyc < 20);
      if (!acc) chk("first_accept_timeout", DW'(0), DW'(1));
      ivalid = 1'b0;
      aresetn = 1'b0;
      @(posedge clk); #1;
      chk("midrow_reset_ovalid", DW'(ovalid), DW'(0));
      chk("midrow_reset_odata", odata, DW'(0));
      chk("midrow_reset_flags", DW'({olast, oframe_done}), DW'(0));
      q.delete(); row_buf.delete(); row_idx = 0;
      @(posedge clk); #1;
      aresetn = 1'b1;

      // two full frames with random gaps and 3-cycle stall bursts
      fed = 0; cyc = 0; stall_cnt = 0;
      while (fed < TOTAL && cyc < 20000) begin
         @(negedge clk); acc = ivalid && iready;
         @(posedge clk); #1; cyc++;
         if (acc) fed++;
         if (stall_cnt > 0) begin
            stall = 1'b1; stall_cnt--;
         end else if ($urandom_range(0, 11) == 0) begin
            stall = 1'b1; stall_cnt = 2;
         end else stall = 1'b0;
         if (ivalid && !acc) begin
            ivalid = 1'b1;
         end else if (fed < TOTAL && $urandom_range(0, 9) < 7) begin
            ivalid = 1'b1; idata = gen_beat(fed);
         end else begin
            ivalid = 1'b0;
         end
      end
      if (fed < TOTAL) chk("feed_timeout", DW'(fed), DW'(TOTAL));
      ivalid = 1'b0; stall = 1'b0;
      cyc = 0;
      while (q.size() != 0 && cyc < 200) begin
         @(posedge clk); cyc++;
      end
      repeat (3) @(posedge clk);
      chk("drain_empty", DW'(q.size()), DW'(0));
      chk("frame_pulses", DW'(frame_pulses), DW'(2));
      chk("row_wrapped", DW'(row_idx), DW'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
